// File: rtl/mem_write_buffer_pkg.sv
// Shared definitions for the posted write buffer: default geometry, memory FSM
// states and the cache request decode used by the cache side of the buffer.
package mem_write_buffer_pkg;

    localparam int unsigned WB_DEPTH  = 4;
    localparam int unsigned WB_ADDR_W = 28;
    localparam int unsigned WB_DATA_W = 128;

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_WRITE = 2'd1,
        M_READ  = 2'd2
    } mstate_t;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_READ  = 2'd1,
        REQ_WRITE = 2'd2
    } req_t;

    // Read and write together is illegal on the cache port; read wins if it happens.
    function automatic req_t decode_req(input logic rd, input logic wr);
        if (rd)
            return REQ_READ;
        else if (wr)
            return REQ_WRITE;
        else
            return REQ_NONE;
    endfunction

endpackage

// File: rtl/wb_cam_fifo.sv
// Line FIFO with a parallel address CAM: youngest-hit lookup, coalescing write
// port into non-in-flight entries, and an in-flight marker on the head entry.
module wb_cam_fifo
    import mem_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = WB_DEPTH,
    parameter int unsigned ADDR_W = WB_ADDR_W,
    parameter int unsigned DATA_W = WB_DATA_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_push,
    input  logic                     i_coal,
    input  logic [$clog2(DEPTH)-1:0] i_coal_idx,
    input  logic                     i_pop,
    input  logic                     i_mark_head,
    output logic                     o_hit,
    output logic [DATA_W-1:0]        o_hit_data,
    output logic                     o_coal_hit,
    output logic [$clog2(DEPTH)-1:0] o_coal_idx,
    output logic [$clog2(DEPTH)-1:0] o_head_idx,
    output logic [ADDR_W-1:0]        o_head_addr,
    output logic [DATA_W-1:0]        o_head_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic              r_valid [DEPTH];
    logic              r_infl  [DEPTH];
    logic [ADDR_W-1:0] r_addr  [DEPTH];
    logic [DATA_W-1:0] r_data  [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [PW:0]       r_count;

    logic [PW-1:0]     w_idx;
    logic [PW-1:0]     w_hit_idx;

    // Scan oldest to youngest so the last match found is the youngest one.
    always_comb begin
        o_hit      = 1'b0;
        o_coal_hit = 1'b0;
        o_coal_idx = '0;
        w_hit_idx  = '0;
        w_idx      = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PW'(k);
            if (r_valid[w_idx] && (r_addr[w_idx] == i_addr)) begin
                o_hit     = 1'b1;
                w_hit_idx = w_idx;
                if (!r_infl[w_idx]) begin
                    o_coal_hit = 1'b1;
                    o_coal_idx = w_idx;
                end
            end
        end
    end

    assign o_hit_data  = r_data[w_hit_idx];
    assign o_head_idx  = r_head;
    assign o_head_addr = r_addr[r_head];
    assign o_head_data = r_data[r_head];
    assign o_count     = r_count;
    assign o_full      = (r_count == (PW+1)'(DEPTH));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_infl[i]  <= 1'b0;
                r_addr[i]  <= '0;
                r_data[i]  <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_pop) begin
                r_valid[r_head] <= 1'b0;
                r_infl[r_head]  <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            if (i_mark_head)
                r_infl[r_head] <= 1'b1;
            if (i_push) begin
                r_valid[r_tail] <= 1'b1;
                r_infl[r_tail]  <= 1'b0;
                r_addr[r_tail]  <= i_addr;
                r_data[r_tail]  <= i_wdata;
                r_tail          <= r_tail + PW'(1);
            end
            if (i_coal)
                r_data[i_coal_idx] <= i_wdata;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_write_buffer.sv
// Posted write buffer between the cache memory port and main memory: cache
// handshake, pending-read register and the in-order memory drain FSM.
module mem_write_buffer
    import mem_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = WB_DEPTH,
    parameter int unsigned ADDR_W = WB_ADDR_W,
    parameter int unsigned DATA_W = WB_DATA_W
) (
    input  logic                   clk,
    input  logic                   proc_reset,
    input  logic                   c_read,
    input  logic                   c_write,
    input  logic [ADDR_W-1:0]      c_addr,
    input  logic [DATA_W-1:0]      c_wdata,
    output logic [DATA_W-1:0]      c_rdata,
    output logic                   c_ready,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    input  logic                   mem_ready,
    output logic [$clog2(DEPTH):0] wb_count
);

    localparam int unsigned PW = $clog2(DEPTH);

    mstate_t           r_mstate, w_mstate_nxt;
    logic              r_c_ready, r_rd_pend;
    logic [DATA_W-1:0] r_c_rdata;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_mem_read, r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_mem_read_nxt, w_mem_write_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    req_t              w_req;
    logic              w_sample, w_wr, w_rd, w_coal, w_push;
    logic              w_pop, w_mark, w_rd_done;
    logic              w_hit, w_coal_hit, w_full;
    logic [PW-1:0]     w_coal_idx, w_head_idx;
    logic [DATA_W-1:0] w_hit_data, w_head_data;
    logic [ADDR_W-1:0] w_head_addr;
    logic [PW:0]       w_count;

    assign w_req    = decode_req(c_read, c_write);
    assign w_sample = !r_c_ready && !r_rd_pend;
    assign w_wr     = w_sample && (w_req == REQ_WRITE);
    assign w_rd     = w_sample && (w_req == REQ_READ);
    assign w_coal   = w_wr && w_coal_hit;
    assign w_push   = w_wr && !w_coal_hit && !w_full;

    wb_cam_fifo #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_fifo (
        .i_clk      (clk),
        .i_rst      (proc_reset),
        .i_addr     (c_addr),
        .i_wdata    (c_wdata),
        .i_push     (w_push),
        .i_coal     (w_coal),
        .i_coal_idx (w_coal_idx),
        .i_pop      (w_pop),
        .i_mark_head(w_mark),
        .o_hit      (w_hit),
        .o_hit_data (w_hit_data),
        .o_coal_hit (w_coal_hit),
        .o_coal_idx (w_coal_idx),
        .o_head_idx (w_head_idx),
        .o_head_addr(w_head_addr),
        .o_head_data(w_head_data),
        .o_count    (w_count),
        .o_full     (w_full)
    );

    always_comb begin
        w_mstate_nxt    = r_mstate;
        w_mem_read_nxt  = r_mem_read;
        w_mem_write_nxt = r_mem_write;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_pop           = 1'b0;
        w_mark          = 1'b0;
        w_rd_done       = 1'b0;
        case (r_mstate)
            M_IDLE: begin
                if (r_rd_pend) begin
                    w_mstate_nxt   = M_READ;
                    w_mem_read_nxt = 1'b1;
                    w_mem_addr_nxt = r_rd_addr;
                end else if (w_count != '0) begin
                    w_mstate_nxt    = M_WRITE;
                    w_mem_write_nxt = 1'b1;
                    w_mem_addr_nxt  = w_head_addr;
                    w_mark          = 1'b1;
                    // A coalesce into the head on launch must reach memory too.
                    w_mem_wdata_nxt = (w_coal && (w_coal_idx == w_head_idx)) ? c_wdata : w_head_data;
                end
            end
            M_WRITE: begin
                if (mem_ready) begin
                    w_mstate_nxt    = M_IDLE;
                    w_mem_write_nxt = 1'b0;
                    w_pop           = 1'b1;
                end
            end
            M_READ: begin
                if (mem_ready) begin
                    w_mstate_nxt   = M_IDLE;
                    w_mem_read_nxt = 1'b0;
                    w_rd_done      = 1'b1;
                end
            end
            default: w_mstate_nxt = M_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_mstate    <= M_IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mstate    <= w_mstate_nxt;
            r_mem_read  <= w_mem_read_nxt;
            r_mem_write <= w_mem_write_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_c_ready <= 1'b0;
            r_c_rdata <= '0;
            r_rd_pend <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_c_ready <= w_coal || w_push || (w_rd && w_hit) || w_rd_done;
            if (w_rd && w_hit)
                r_c_rdata <= w_hit_data;
            else if (w_rd_done)
                r_c_rdata <= mem_rdata;
            if (w_rd && !w_hit) begin
                r_rd_pend <= 1'b1;
                r_rd_addr <= c_addr;
            end else if (w_rd_done) begin
                r_rd_pend <= 1'b0;
            end
        end
    end

    assign c_ready   = r_c_ready;
    assign c_rdata   = r_c_rdata;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign wb_count  = w_count;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer: bench drives memory handshake by hand and
// checks every response against hand-computed values with immediate assertions.
module tb_mem_write_buffer;

    logic         clk;
    logic         proc_reset;
    logic         c_read, c_write;
    logic [27:0]  c_addr;
    logic [127:0] c_wdata, c_rdata;
    logic         c_ready;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready;
    logic [2:0]   wb_count;

    int n_checks = 0;
    int n_errors = 0;
    int n_rd_cycles = 0;
    bit illegal_seen = 1'b0;

    localparam logic [127:0] DA = {4{32'hA0A0_0001}};
    localparam logic [127:0] DB = {4{32'hB0B0_0002}};
    localparam logic [127:0] DC = {4{32'hC0C0_0003}};
    localparam logic [127:0] DD = {4{32'hD0D0_0004}};
    localparam logic [127:0] DE = {4{32'hE0E0_0005}};
    localparam logic [127:0] DF = {4{32'hF0F0_0006}};
    localparam logic [127:0] DG = {4{32'h1234_5678}};
    localparam logic [127:0] DH = {4{32'h8765_4321}};

    mem_write_buffer #(.DEPTH(4), .ADDR_W(28), .DATA_W(128)) dut (
        .clk       (clk),
        .proc_reset(proc_reset),
        .c_read    (c_read),
        .c_write   (c_write),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_rdata   (c_rdata),
        .c_ready   (c_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .wb_count  (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_read) n_rd_cycles++;
        if (c_read && c_write) illegal_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Holds the write through the c_ready cycle, then drops it.
    task automatic do_write(input logic [27:0] a, input logic [127:0] d, output int lat, output int cnt);
        c_write = 1'b1; c_addr = a; c_wdata = d;
        lat = 0; cnt = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (c_ready) begin
                lat = i;
                cnt = int'(wb_count);
                break;
            end
        end
        tick();
        c_write = 1'b0;
    endtask

    task automatic wait_mw(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (mem_write) seen = 1'b1;
            else tick();
        end
        chk(tag, 128'(seen), 128'd1);
    endtask

    task automatic mem_ack(input logic [127:0] rd);
        mem_rdata = rd;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
    endtask

    initial begin
        int lat, cnt, rd_before;
        bit stall_ok;
        logic [27:0] t5_exp [4];
        t5_exp = '{28'h41, 28'h42, 28'h43, 28'h50};

        proc_reset = 1'b1; c_read = 1'b0; c_write = 1'b0; c_addr = '0; c_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        tick(); tick();
        chk("rst_c_ready", c_ready, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_count", wb_count, 0);
        chk("rst_c_rdata", c_rdata, 0);
        proc_reset = 1'b0;
        tick();

        // Single write, accepted in one cycle, drained after a slow memory
        do_write(28'h10, DA, lat, cnt);
        chk("t2_lat", lat, 1);
        chk("t2_cnt", cnt, 1);
        wait_mw("t2_mw");
        chk("t2_addr", mem_addr, 28'h10);
        chk("t2_data", mem_wdata, DA);
        repeat (4) tick();
        chk("t2_hold", {mem_write, mem_addr}, {1'b1, 28'h10});
        mem_ack('0);
        chk("t2_drop", mem_write, 0);
        chk("t2_cnt0", wb_count, 0);
        tick();

        // Coalesce behind an in-flight write
        do_write(28'h18, DD, lat, cnt);
        wait_mw("t3_mw18");
        do_write(28'h20, DA, lat, cnt);
        chk("t3_cnt_a", cnt, 2);
        do_write(28'h20, DB, lat, cnt);
        chk("t3_lat_b", lat, 1);
        chk("t3_cnt_b", wb_count, 2);
        chk("t3_addr18", mem_addr, 28'h18);
        mem_ack('0);
        chk("t3_cnt1", wb_count, 1);
        chk("t3_gap", mem_write, 0);
        tick();
        chk("t3_mw20", {mem_write, mem_addr}, {1'b1, 28'h20});
        chk("t3_data_b", mem_wdata, DB);
        mem_ack('0);
        chk("t3_cnt0", wb_count, 0);
        repeat (3) tick();
        chk("t3_once", mem_write, 0);

        // Read hit on a buffered line
        rd_before = n_rd_cycles;
        do_write(28'h28, DE, lat, cnt);
        wait_mw("t4_mw28");
        do_write(28'h30, DC, lat, cnt);
        chk("t4_cnt", cnt, 2);
        c_read = 1'b1; c_addr = 28'h30;
        tick();
        chk("t4_ready", c_ready, 1);
        chk("t4_rdata", c_rdata, DC);
        tick();
        c_read = 1'b0;
        mem_ack('0);
        tick();
        chk("t4_mw30", {mem_write, mem_addr}, {1'b1, 28'h30});
        chk("t4_data", mem_wdata, DC);
        mem_ack('0);
        chk("t4_cnt0", wb_count, 0);
        chk("t4_no_mem_read", n_rd_cycles - rd_before, 0);

        // Full buffer stalls the fifth write until a drain pops
        do_write(28'h40, DA, lat, cnt);
        do_write(28'h41, DB, lat, cnt);
        do_write(28'h42, DC, lat, cnt);
        do_write(28'h43, DD, lat, cnt);
        chk("t5_full", cnt, 4);
        c_write = 1'b1; c_addr = 28'h50; c_wdata = DF;
        stall_ok = 1'b1;
        repeat (3) begin
            tick();
            if (c_ready) stall_ok = 1'b0;
        end
        chk("t5_stall", 128'(stall_ok), 1);
        chk("t5_cnt4", wb_count, 4);
        mem_ack('0);
        chk("t5_pop_no_ready", c_ready, 0);
        chk("t5_cnt3", wb_count, 3);
        tick();
        chk("t5_accept", c_ready, 1);
        chk("t5_cnt_back4", wb_count, 4);
        chk("t5_mw41", {mem_write, mem_addr}, {1'b1, 28'h41});
        tick();
        c_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_mw("t5_drain_mw");
            chk("t5_drain_addr", mem_addr, t5_exp[i]);
            mem_ack('0);
        end
        chk("t5_cnt0", wb_count, 0);

        // Miss read bypasses buffered writes but waits for the in-flight one
        do_write(28'h58, DE, lat, cnt);
        wait_mw("t6_mw58");
        do_write(28'h60, DG, lat, cnt);
        chk("t6_cnt", cnt, 2);
        c_read = 1'b1; c_addr = 28'h70;
        repeat (3) tick();
        chk("t6_wait_ready", c_ready, 0);
        chk("t6_no_preempt", mem_read, 0);
        mem_ack('0);
        chk("t6_idle", {mem_read, mem_write}, 2'b00);
        tick();
        chk("t6_mr70", {mem_read, mem_write, mem_addr}, {2'b10, 28'h70});
        mem_ack(DH);
        chk("t6_ready", c_ready, 1);
        chk("t6_rdata", c_rdata, DH);
        chk("t6_mr_drop", mem_read, 0);
        chk("t6_cnt1", wb_count, 1);
        tick();
        c_read = 1'b0;
        chk("t6_mw60", {mem_write, mem_addr}, {1'b1, 28'h60});
        chk("t6_data", mem_wdata, DG);
        mem_ack('0);
        chk("t6_cnt0", wb_count, 0);

        // Asynchronous reset in the middle of a memory write
        do_write(28'h05, DA, lat, cnt);
        wait_mw("t1_mw05");
        #3;
        proc_reset = 1'b1;
        #1;
        chk("t1_mw_async", mem_write, 0);
        chk("t1_cnt", wb_count, 0);
        chk("t1_ready", c_ready, 0);
        chk("t1_addr", mem_addr, 0);
        tick();
        proc_reset = 1'b0;
        tick(); tick();
        chk("t1_discard", {mem_write, wb_count}, 4'b0000);

        chk("no_illegal_req", 128'(illegal_seen), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
